// File: rtl/cdc_hs_rx.sv
// Receive end of a 4-phase req/ack handshake: synchronizes the source's level
// request, captures the held word into a one-entry valid/ready buffer, and returns ack.
module cdc_hs_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_dst,
    input  logic                 async_reset,
    input  logic                 req_async,
    input  logic [WIDTH-1:0]     data_async,
    output logic                 ack_async,
    output logic                 dst_valid,
    output logic [WIDTH-1:0]     dst_data,
    input  logic                 dst_ready,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ack;
    logic                   r_valid;
    logic [WIDTH-1:0]       r_data;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic w_req_s;
    logic w_pop;
    logic w_buf_free;
    logic w_capture;
    logic w_ack_nxt;

    // Only the request crosses domains; data_async is sampled solely once req_s is high.
    always_ff @(posedge clk_dst or negedge async_reset) begin
        if (!async_reset) r_sync <= '0;
        else              r_sync <= {r_sync[SYNC_STAGES-2:0], req_async};
    end

    assign w_req_s    = r_sync[SYNC_STAGES-1];
    assign w_pop      = r_valid && dst_ready;
    assign w_buf_free = !r_valid || w_pop;

    always_ff @(posedge clk_dst or negedge async_reset) begin
        if (!async_reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                // Holding ack low while the buffer is full is the backpressure path.
                if (w_req_s && w_buf_free) begin
                    w_capture   = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!w_req_s) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_dst or negedge async_reset) begin
        if (!async_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_data  <= data_async;
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign ack_async  = r_ack;
    assign dst_valid  = r_valid;
    assign dst_data   = r_data;
    assign xfer_count = r_cnt;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Scoreboard bench for cdc_hs_rx: a jittered source handshake pushes expected
// words, a negedge monitor pops and compares every accepted word.
module tb_cdc_hs_rx;

    localparam int WIDTH = 8;
    localparam int SS    = 2;
    localparam int CW    = 4;

    logic             clk_dst = 1'b0;
    logic             async_reset;
    logic             req_async;
    logic [WIDTH-1:0] data_async;
    logic             ack_async;
    logic             dst_valid;
    logic [WIDTH-1:0] dst_data;
    logic             dst_ready;
    logic [CW-1:0]    xfer_count;

    cdc_hs_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
        .clk_dst    (clk_dst),
        .async_reset(async_reset),
        .req_async  (req_async),
        .data_async (data_async),
        .ack_async  (ack_async),
        .dst_valid  (dst_valid),
        .dst_data   (dst_data),
        .dst_ready  (dst_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk_dst = ~clk_dst;

    int n_chk  = 0;
    int n_fail = 0;
    int n_cap  = 0;      // model: captures since last reset
    int n_acc  = 0;      // words accepted downstream
    int ack_rises = 0;
    bit rand_rdy  = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one accept per negedge where valid&&ready (ready only changes after posedge).
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_ack  = 1'b0;
    always @(negedge clk_dst) begin
        if (async_reset) begin
            if (prev_hold && dst_valid) chk("dst_data_hold", dst_data, prev_data);
            if (dst_valid && dst_ready) begin
                n_acc++;
                if (exp_q.size() == 0) chk("pop_on_empty_queue", 32'd1, 32'd0);
                else                   chk("dst_data", dst_data, exp_q.pop_front());
            end
            if (ack_async && !prev_ack) ack_rises++;
            prev_hold = dst_valid && !dst_ready;
            prev_data = dst_data;
            prev_ack  = ack_async;
        end else begin
            prev_hold = 1'b0;
            prev_ack  = 1'b0;
        end
    end

    always @(posedge clk_dst) begin
        #1;
        if (rand_rdy) dst_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_ack(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_dst);
            if (ack_async === lvl) begin ok = 1'b1; return; end
        end
        chk("ack_timeout", 32'd0, 32'd1);
    endtask

    // One full 4-phase transfer with jittered req edges.
    task automatic send(input logic [WIDTH-1:0] d, output bit ok);
        @(negedge clk_dst);
        #($urandom_range(1, 4));
        data_async = d;
        exp_q.push_back(d);
        req_async = 1'b1;
        wait_ack(1'b1, ok);
        if (!ok) return;
        n_cap++;
        chk("xfer_count_on_ack", xfer_count, n_cap % (1 << CW));
        repeat ($urandom_range(0, 2)) @(negedge clk_dst);
        #($urandom_range(1, 4));
        req_async = 1'b0;
        wait_ack(1'b0, ok);
    endtask

    task automatic drain();
        dst_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_dst);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    bit ok;
    int rises0;

    initial begin
        async_reset = 1'b0;
        req_async   = 1'b0;
        data_async  = '0;
        dst_ready   = 1'b0;
        repeat (3) @(negedge clk_dst);
        chk("rst_ack", ack_async, 0);
        chk("rst_valid", dst_valid, 0);
        chk("rst_data", dst_data, 0);
        chk("rst_count", xfer_count, 0);
        #2 async_reset = 1'b1;

        // Basic transfer with exact latency.
        dst_ready = 1'b1;
        @(negedge clk_dst);
        data_async = 8'hA5;
        exp_q.push_back(8'hA5);
        req_async = 1'b1;
        @(negedge clk_dst); chk("lat_e0_valid", dst_valid, 0);
        @(negedge clk_dst); chk("lat_e1_valid", dst_valid, 0);
        @(negedge clk_dst);
        chk("lat_e2_valid", dst_valid, 1);
        chk("lat_e2_ack", ack_async, 1);
        chk("lat_e2_data", dst_data, 8'hA5);
        n_cap++;
        chk("basic_count", xfer_count, 1);
        req_async = 1'b0;
        @(negedge clk_dst); chk("ackfall_e0", ack_async, 1);
        @(negedge clk_dst); chk("ackfall_e1", ack_async, 1);
        @(negedge clk_dst); chk("ackfall_e2", ack_async, 0);

        // Backpressure: second word must stall until the first is popped.
        @(posedge clk_dst); #1 dst_ready = 1'b0;
        send(8'h11, ok);
        @(negedge clk_dst); #2;
        data_async = 8'h22;
        exp_q.push_back(8'h22);
        req_async = 1'b1;
        repeat (8) @(negedge clk_dst);
        chk("bp_ack_low", ack_async, 0);
        chk("bp_valid", dst_valid, 1);
        chk("bp_data_held", dst_data, 8'h11);
        @(posedge clk_dst); #1 dst_ready = 1'b1;
        @(posedge clk_dst); #1 dst_ready = 1'b0;
        @(negedge clk_dst);
        n_cap++;
        chk("bp_valid_after", dst_valid, 1);
        chk("bp_data_new", dst_data, 8'h22);
        chk("bp_ack", ack_async, 1);
        chk("bp_count", xfer_count, n_cap % (1 << CW));
        #2 req_async = 1'b0;
        wait_ack(1'b0, ok);
        drain();

        // Mid-transfer reset in WAIT_LOW with req high and word still buffered.
        @(posedge clk_dst); #1 dst_ready = 1'b0;
        @(negedge clk_dst); #2;
        data_async = 8'h5C;
        exp_q.push_back(8'h5C);
        req_async = 1'b1;
        wait_ack(1'b1, ok);
        #2 async_reset = 1'b0;
        #1;
        chk("mrst_ack", ack_async, 0);
        chk("mrst_valid", dst_valid, 0);
        chk("mrst_data", dst_data, 0);
        chk("mrst_count", xfer_count, 0);
        exp_q.delete();
        exp_q.push_back(8'h5C);
        n_cap = 0;
        dst_ready = 1'b1;
        @(negedge clk_dst); #2 async_reset = 1'b1;
        @(negedge clk_dst); chk("rel_e0_valid", dst_valid, 0);
        @(negedge clk_dst); chk("rel_e1_valid", dst_valid, 0);
        @(negedge clk_dst);
        n_cap++;
        chk("rel_e2_valid", dst_valid, 1);
        chk("rel_e2_data", dst_data, 8'h5C);
        chk("rel_count", xfer_count, 1);
        #2 req_async = 1'b0;
        wait_ack(1'b0, ok);

        // Stream 0x00..0x0F; 17 captures since reset wraps the 4-bit counter to 1.
        rises0 = ack_rises;
        for (int i = 0; i < 16 && ok; i++) send(8'(i), ok);
        @(negedge clk_dst);
        chk("stream_ack_rises", ack_rises - rises0, 16);
        chk("wrap_count", xfer_count, 1);
        drain();

        // Random timing and random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000 && ok; i++) send(8'($urandom), ok);
        rand_rdy = 1'b0;
        @(posedge clk_dst); #1;
        drain();
        chk("final_count", xfer_count, n_cap % (1 << CW));
        chk("accepted_vs_captured", n_acc, n_cap + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cdc_hs_rx.md
Name: cdc_hs_rx

Overview:
- Destination-side end of a 4-phase req/ack handshake that carries a multi-bit word into the clk_dst domain.
- Synchronizes the source's level request and captures the word, which the source holds stable while req is high.
- Presents the captured word downstream on a valid/ready interface and returns a registered ack level to the source domain.
- Pairs with a source-side transmitter that drives req_async/data_async and synchronizes ack_async.

Parameters:
- WIDTH, 8, data word width in bits.
- SYNC_STAGES, 2, flops in the req synchronizer chain; legal values >= 2.
- CNT_WIDTH, 16, width of the completed-transfer counter.

Ports:
- clk_dst  input  1  destination clock; the only clock in the block.
- async_reset  input  1  asynchronous, active-low reset; asserts immediately, no clock needed.
- req_async  input  1  level request from source domain; asynchronous to clk_dst.
- data_async  input  WIDTH  source data; guaranteed stable from req rise until ack is seen high.
- ack_async  output  1  level acknowledge to source domain; driven directly from a flop.
- dst_valid  output  1  captured word available downstream.
- dst_data  output  WIDTH  captured word.
- dst_ready  input  1  downstream accepts the word when dst_valid && dst_ready.
- xfer_count  output  CNT_WIDTH  number of words captured since reset.

Behaviour:
- Reset (async_reset low): all flops, including the sync chain, go to 0. Reset values: ack_async=0, dst_valid=0, dst_data=0, xfer_count=0, FSM=IDLE.
- req_s is the last stage of the SYNC_STAGES-flop chain clocked by clk_dst.
- data_async is never synchronized. It is sampled only when req_s=1, which protocol guarantees is a stable window.
- Output buffer is one entry. It is "free" when !dst_valid, or when dst_valid && dst_ready in the same cycle (capture and pop may coincide).

FSM, two states:
- IDLE (ack_async=0):
  - If req_s=1 and buffer free: dst_data<=data_async, dst_valid<=1, ack_async<=1, xfer_count<=xfer_count+1, go to WAIT_LOW.
  - If req_s=1 and buffer not free: stay in IDLE with ack low. This stalls the source (backpressure); no data loss, no overwrite.
  - If req_s=0: stay.
- WAIT_LOW (ack_async=1):
  - When req_s=0: ack_async<=0, go to IDLE.
  - Otherwise stay. No capture occurs in this state.

Downstream interface:
- dst_valid clears on dst_valid && dst_ready unless a new capture happens in the same cycle; in that case it stays 1 and dst_data takes the new word.
- dst_data is held stable while dst_valid=1 and not accepted.

Latency and counting:
- Latency: req_async high and meeting setup at edge 0 gives req_s=1 after edge SYNC_STAGES-1. dst_valid and ack_async rise at edge SYNC_STAGES, if the buffer is free.
- Minimum full 4-phase cycle as seen at the receiver: 2*SYNC_STAGES+2 clk_dst edges, plus source-side sync delay.
- xfer_count wraps from 2^CNT_WIDTH-1 to 0 with no flag. It increments exactly once per capture.

Boundary conditions:
- A req pulse that drops before reaching req_s is a protocol violation. Behaviour is undefined, but the FSM must not deadlock.
- Reset mid-transfer: everything clears. If req_async is still high after reset release, it is treated as a new request and captured again. The source must tolerate this duplicate.
- dst_ready is ignored while dst_valid=0.

Test Plan:
- Basic transfer (WIDTH=8, SYNC_STAGES=2, dst_ready=1): data 0xA5, raise req -> dst_valid=1 and dst_data=0xA5 at edge 2; ack_async=1 at the same edge; drop req -> ack_async=0 two edges later; xfer_count=1.
- Backpressure (dst_ready=0): send 0x11, then 0x22 -> 0x22 not captured and ack stays 0 while dst_valid holds 0x11. Pulse dst_ready for 1 cycle -> 0x22 captured on that edge, dst_valid stays 1; xfer_count=2.
- Back-to-back stream of 0x00..0x0F with dst_ready=1 -> 16 words in order, no duplicates, xfer_count=16, ack toggles 16 times.
- Counter wrap (CNT_WIDTH=4): 17 transfers -> xfer_count=1.
- Mid-transfer reset: assert async_reset while in WAIT_LOW with req high -> all outputs 0 immediately without a clock edge. Release with req still high -> recapture at edge 2 after release; xfer_count=1.
- Random async timing: req edges jittered relative to clk_dst, 1000 words, random dst_ready -> scoreboard exact match, no drop or overwrite.
